// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - TileLink opcodes, responder states and beat-count helper
package tl_pkg;

  localparam logic [2:0] A_PUT_FULL    = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] A_ARITHMETIC  = 3'd2;
  localparam logic [2:0] A_LOGICAL     = 3'd3;
  localparam logic [2:0] A_GET         = 3'd4;
  localparam logic [2:0] A_INTENT      = 3'd5;

  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK        = 3'd2;

  localparam logic [3:0] MAX_SIZE = 4'd6;

  typedef enum logic [1:0] {IDLE, READ, WRITE, ACK} tl_state_e;

  // Oversized requests are denied anyway; clamping keeps the count within 16 beats.
  function automatic logic [4:0] beats_from_size(input logic [3:0] size);
    logic [3:0] s;
    s = (size > MAX_SIZE) ? MAX_SIZE : size;
    return (s <= 4'd2) ? 5'd1 : (5'd1 << (s - 4'd2));
  endfunction

endpackage

// File: rtl/sram_1rw_be.sv
// rtl/sram_1rw_be.sv - single-port 32-bit SRAM with byte enables and registered read data
module sram_1rw_be #(
  parameter int    DEPTH_WORDS = 4096,
  parameter string INIT_FILE   = "",
  parameter int    AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Read-first: a write cycle returns the old word, which the responder never uses.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/icache_mem_responder.sv
// rtl/icache_mem_responder.sv - TL-UH slave serving icache refills and loads from on-chip SRAM
module icache_mem_responder
  import tl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter string       INIT_FILE   = ""
) (
  input  logic        cpu_clock_i,
  input  logic        reset_i,
  input  logic [2:0]  a_opcode,
  input  logic [2:0]  a_param,
  input  logic [3:0]  a_size,
  input  logic [31:0] a_address,
  input  logic [3:0]  a_mask,
  input  logic [31:0] a_data,
  input  logic        a_corrupt,
  input  logic        a_valid,
  output logic        a_ready,
  output logic [2:0]  d_opcode,
  output logic [1:0]  d_param,
  output logic [3:0]  d_size,
  output logic        d_denied,
  output logic [31:0] d_data,
  output logic        d_corrupt,
  output logic        d_valid,
  input  logic        d_ready
);

  localparam int IW = $clog2(DEPTH_WORDS);

  tl_state_e   state, state_nxt;
  logic [3:0]  cnt, size_r;
  logic [2:0]  op_r;
  logic [IW-1:0] idx, a_index, mem_addr;
  logic        denied, mem_we;
  logic [31:0] off, rdata;
  logic [4:0]  beats;
  logic        a_fire, d_fire, is_get, is_put, req_denied;
  logic        unused;

  assign off     = a_address - BASE_ADDR;
  assign a_index = off[IW+1:2];
  assign beats   = beats_from_size(a_size);
  assign is_get  = (a_opcode == A_GET);
  assign is_put  = (a_opcode == A_PUT_FULL) || (a_opcode == A_PUT_PARTIAL);
  assign a_fire  = a_valid && a_ready;
  assign d_fire  = d_valid && d_ready;
  assign d_param = 2'b00;
  assign d_size  = size_r;
  assign unused  = ^{a_param, off[1:0]};

  // Addresses below BASE_ADDR wrap to huge offsets and fall out of range.
  assign req_denied = ({2'b00, off[31:2]} >= 32'(DEPTH_WORDS))
                   || ((a_address & ((32'd1 << a_size) - 32'd1)) != 32'd0)
                   || (a_size > MAX_SIZE)
                   || !(is_get || is_put)
                   || (is_put && a_corrupt);

  sram_1rw_be #(.DEPTH_WORDS(DEPTH_WORDS), .INIT_FILE(INIT_FILE)) u_sram (
    .clk   (cpu_clock_i),
    .we    (mem_we),
    .be    (a_mask),
    .addr  (mem_addr),
    .wdata (a_data),
    .rdata (rdata)
  );

  always_ff @(posedge cpu_clock_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    a_ready   = 1'b0;
    d_valid   = 1'b0;
    d_opcode  = D_ACCESS_ACK;
    d_denied  = 1'b0;
    d_corrupt = 1'b0;
    d_data    = 32'd0;
    mem_we    = 1'b0;
    mem_addr  = idx;
    case (state)
      IDLE: begin
        a_ready  = !reset_i;
        mem_addr = a_index;
        if (a_fire) begin
          if (is_get) begin
            state_nxt = READ;
          end else if (is_put) begin
            mem_we    = !req_denied;
            state_nxt = (beats > 5'd1) ? WRITE : ACK;
          end else begin
            state_nxt = ACK;
          end
        end
      end
      READ: begin
        d_valid   = 1'b1;
        d_opcode  = D_ACCESS_ACK_DATA;
        d_denied  = denied;
        d_corrupt = denied;
        d_data    = denied ? 32'd0 : rdata;
        // Prefetch the next word on a fire so beats stream without bubbles.
        if (d_fire) begin
          mem_addr = idx + 1'b1;
          if (cnt == 4'd0) state_nxt = IDLE;
        end
      end
      WRITE: begin
        a_ready = !reset_i;
        if (a_fire) begin
          mem_we = !(denied || a_corrupt);
          if (cnt == 4'd1) state_nxt = ACK;
        end
      end
      ACK: begin
        d_valid = 1'b1;
        case (op_r)
          A_PUT_FULL, A_PUT_PARTIAL: begin
            d_opcode = D_ACCESS_ACK;
            d_denied = denied;
          end
          A_INTENT: d_opcode = D_HINT_ACK;
          default: begin
            d_opcode  = D_ACCESS_ACK_DATA;
            d_denied  = 1'b1;
            d_corrupt = 1'b1;
          end
        endcase
        if (d_fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // For Puts idx points at the next word to write; for Gets at the word on the D channel.
  always_ff @(posedge cpu_clock_i) begin
    if (reset_i) begin
      cnt    <= 4'd0;
      idx    <= '0;
      denied <= 1'b0;
      size_r <= 4'd0;
      op_r   <= 3'd0;
    end else begin
      case (state)
        IDLE: if (a_fire) begin
          size_r <= a_size;
          op_r   <= a_opcode;
          denied <= req_denied;
          cnt    <= 4'(beats - 5'd1);
          idx    <= is_put ? a_index + 1'b1 : a_index;
        end
        READ: if (d_fire) begin
          idx <= idx + 1'b1;
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        WRITE: if (a_fire) begin
          idx    <= idx + 1'b1;
          cnt    <= cnt - 4'd1;
          denied <= denied || a_corrupt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_mem_responder.sv
// tb/tb_icache_mem_responder.sv - scoreboard bench for icache_mem_responder
module tb_icache_mem_responder;
  import tl_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [2:0]  a_opcode = 3'd0, a_param = 3'd0;
  logic [3:0]  a_size = 4'd0, a_mask = 4'd0;
  logic [31:0] a_address = 32'd0, a_data = 32'd0;
  logic        a_corrupt = 1'b0, a_valid = 1'b0, a_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [3:0]  d_size;
  logic        d_denied, d_corrupt, d_valid;
  logic [31:0] d_data;
  logic        d_ready = 1'b1;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  size;
    logic        denied;
    logic        corrupt;
    logic [31:0] data;
  } d_exp_t;

  d_exp_t      sb[$];
  d_exp_t      e;
  logic [31:0] model [DEPTH];
  int          n_checks = 0, n_pass = 0;
  int          cycle = 0, fires = 0, first_cyc = 0, last_cyc = 0, fc = 0;

  icache_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .INIT_FILE("")) dut (
    .cpu_clock_i (clk),
    .reset_i     (reset_i),
    .a_opcode    (a_opcode),
    .a_param     (a_param),
    .a_size      (a_size),
    .a_address   (a_address),
    .a_mask      (a_mask),
    .a_data      (a_data),
    .a_corrupt   (a_corrupt),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .d_opcode    (d_opcode),
    .d_param     (d_param),
    .d_size      (d_size),
    .d_denied    (d_denied),
    .d_data      (d_data),
    .d_corrupt   (d_corrupt),
    .d_valid     (d_valid),
    .d_ready     (d_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (!reset_i && d_valid) begin
      if (d_ready) begin
        expect_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          expect_eq("d_opcode", 32'(d_opcode), 32'(e.op));
          expect_eq("d_size", 32'(d_size), 32'(e.size));
          expect_eq("d_denied", 32'(d_denied), 32'(e.denied));
          expect_eq("d_corrupt", 32'(d_corrupt), 32'(e.corrupt));
          expect_eq("d_data", d_data, e.data);
        end
        if (fires == 0) first_cyc = cycle;
        last_cyc = cycle;
        fires++;
      end else if (sb.size() != 0) begin
        expect_eq("stall_data", d_data, sb[0].data);
      end
    end
  end

  task automatic a_send(input logic [2:0] op, input logic [3:0] size, input logic [31:0] addr,
                        input logic [3:0] mask, input logic [31:0] data, input logic corrupt,
                        input logic in_write);
    logic fired;
    fired = 1'b0;
    a_valid = 1'b1; a_opcode = op; a_size = size; a_address = addr;
    a_mask = mask; a_data = data; a_corrupt = corrupt;
    for (int k = 0; k < 50 && !fired; k++) begin
      @(negedge clk);
      if (a_ready) begin
        fired = 1'b1;
        if (in_write) expect_eq("write_no_dvalid", 32'(d_valid), 32'd0);
      end
      @(posedge clk); #1;
    end
    a_valid = 1'b0; a_corrupt = 1'b0;
    expect_eq("a_fire", 32'(fired), 32'd1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    expect_eq("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_put(input logic [2:0] op, input logic [31:0] off, input logic [3:0] size,
                        input logic [3:0] mask, input logic [31:0] d0, input logic [31:0] step,
                        input int bad_beat);
    int n, wi;
    logic bad;
    logic [31:0] w;
    n = (size <= 4'd2) ? 1 : (1 << (size - 4'd2));
    bad = 1'b0;
    for (int k = 0; k < n; k++) begin
      w = d0 + step * 32'(k);
      bad = bad || (k == bad_beat);
      if (!bad) begin
        wi = (int'(off >> 2) + k) % DEPTH;
        for (int b = 0; b < 4; b++)
          if (mask[b]) model[wi][8*b +: 8] = w[8*b +: 8];
      end
      a_send(op, size, BASE + off, mask, w, k == bad_beat, k > 0);
    end
    sb.push_back('{D_ACCESS_ACK, size, bad, 1'b0, 32'd0});
    wait_drain();
  endtask

  task automatic do_get(input logic [31:0] addr, input logic [3:0] size, input logic den);
    int n, bi;
    n = (size <= 4'd2) ? 1 : (1 << (size - 4'd2));
    bi = int'((addr - BASE) >> 2);
    for (int k = 0; k < n; k++)
      sb.push_back('{D_ACCESS_ACK_DATA, size, den, den, den ? 32'd0 : model[(bi + k) % DEPTH]});
    a_send(A_GET, size, addr, 4'hF, 32'd0, 1'b0, 1'b0);
    fc = cycle;
  endtask

  task automatic do_misc(input logic [2:0] op, input logic [2:0] dop, input logic den);
    sb.push_back('{dop, 4'd2, den, den, 32'd0});
    a_send(op, 4'd2, BASE, 4'hF, 32'd0, 1'b0, 1'b0);
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog n_checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
    @(posedge clk); @(negedge clk);
    expect_eq("rst_a_ready", 32'(a_ready), 32'd0);
    expect_eq("rst_d_valid", 32'(d_valid), 32'd0);
    expect_eq("rst_d_denied", 32'(d_denied), 32'd0);
    expect_eq("rst_d_corrupt", 32'(d_corrupt), 32'd0);
    expect_eq("rst_d_opcode", 32'(d_opcode), 32'd0);
    expect_eq("rst_d_size", 32'(d_size), 32'd0);
    expect_eq("rst_d_data", d_data, 32'd0);
    @(posedge clk); #1 reset_i = 1'b0;
    @(negedge clk);
    expect_eq("idle_a_ready", 32'(a_ready), 32'd1);
    @(posedge clk); #1;

    for (int b = 0; b < 8; b++)
      do_put(A_PUT_FULL, 32'(64 * b), 4'd6, 4'hF, 32'(16 * b), 32'd1, -1);

    fires = 0;
    do_get(BASE + 32'h40, 4'd6, 1'b0);
    wait_drain();
    expect_eq("beat0_latency", 32'(first_cyc), 32'(fc));
    expect_eq("burst_back2back", 32'(last_cyc), 32'(fc + 15));
    expect_eq("burst_beats", 32'(fires), 32'd16);

    fires = 0;
    do_get(BASE + 32'h40, 4'd6, 1'b0);
    for (int k = 0; k < 200 && sb.size() != 0; k++) begin
      @(negedge clk);
      if (sb.size() != 0) expect_eq("busy_no_aready", 32'(a_ready), 32'd0);
      @(posedge clk); #1;
      d_ready = ~d_ready;
    end
    d_ready = 1'b1;
    wait_drain();
    expect_eq("stall_beats", 32'(fires), 32'd16);

    do_put(A_PUT_PARTIAL, 32'h8, 4'd2, 4'b0011, 32'hAABBCCDD, 32'd0, -1);
    do_get(BASE + 32'h8, 4'd2, 1'b0);
    wait_drain();

    do_put(A_PUT_FULL, 32'h100, 4'd4, 4'hF, 32'hC0DE0000, 32'h11111111, -1);
    do_get(BASE + 32'h100, 4'd4, 1'b0);
    wait_drain();

    do_get(BASE + 32'(4 * DEPTH), 4'd4, 1'b1); wait_drain();
    do_get(BASE + 32'h4, 4'd4, 1'b1);          wait_drain();
    do_get(BASE - 32'h10, 4'd4, 1'b1);         wait_drain();
    do_put(A_PUT_FULL, 32'h14, 4'd2, 4'hF, 32'hDEADBEEF, 32'd0, 0);
    do_get(BASE + 32'h14, 4'd2, 1'b0); wait_drain();
    do_put(A_PUT_FULL, 32'h20, 4'd3, 4'hF, 32'h5A5A0000, 32'd1, 1);
    do_get(BASE + 32'h20, 4'd3, 1'b0); wait_drain();
    do_misc(A_ARITHMETIC, D_ACCESS_ACK_DATA, 1'b1);
    do_misc(A_LOGICAL, D_ACCESS_ACK_DATA, 1'b1);
    do_misc(A_INTENT, D_HINT_ACK, 1'b0);

    fires = 0;
    do_get(BASE + 32'h40, 4'd6, 1'b0);
    for (int k = 0; k < 100 && fires < 5; k++) begin
      @(posedge clk); #1;
    end
    expect_eq("rst_mid_beats", 32'(fires), 32'd5);
    reset_i = 1'b1;
    @(negedge clk);
    expect_eq("rst_mid_a_ready", 32'(a_ready), 32'd0);
    @(posedge clk); #1 reset_i = 1'b0;
    sb.delete();
    @(negedge clk);
    expect_eq("rst_mid_d_valid", 32'(d_valid), 32'd0);
    expect_eq("rst_mid_a_ready_after", 32'(a_ready), 32'd1);
    @(posedge clk); #1;
    do_get(BASE + 32'h40, 4'd4, 1'b0);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
